// File: rtl/counter_pkg.sv
// counter_pkg -- shared definitions for modulo up/down counters.
//
// Contents:
//   CNT_UP / CNT_DOWN  direction encodings for the 'up' input
//   CNT_MAX_W          widest counter the helper function supports
//   cnt_next_t         next-count result: new value plus wrap flag
//   next_count()       one counting step over 0..mod_max, wrapping or
//                      saturating at the range ends
//
// The helper works on CNT_MAX_W-bit values so any counter up to that
// width can reuse it; callers zero-extend their count and truncate the
// result back to their own width.

package counter_pkg;

   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DOWN = 1'b0;

   localparam int CNT_MAX_W = 32;

   typedef struct packed {
      logic [CNT_MAX_W-1:0] value;
      logic                 wrap;
   } cnt_next_t;

   // One count step. The range end is tested before the add/subtract,
   // so value+1 is never formed at mod_max and value-1 never at 0.
   function automatic cnt_next_t next_count(
      input logic [CNT_MAX_W-1:0] value,
      input logic                 up,
      input logic [CNT_MAX_W-1:0] mod_max,
      input logic                 sat
   );
      cnt_next_t r;
      r.value = value;
      r.wrap  = 1'b0;
      if (up == CNT_UP) begin
         if (value == mod_max) begin
            if (!sat) begin
               r.value = '0;
               r.wrap  = 1'b1;
            end
         end else begin
            r.value = value + CNT_MAX_W'(1);
         end
      end else begin
         if (value == '0) begin
            if (!sat) begin
               r.value = mod_max;
               r.wrap  = 1'b1;
            end
         end else begin
            r.value = value - CNT_MAX_W'(1);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/counter_mod.sv
// counter_mod -- loadable up/down modulo counter over 0..MOD_MAX.
//
// Parameters:
//   WIDTH    counter width in bits (1..32)
//   MOD_MAX  highest count value, <= 2**WIDTH-1
//   RST_VAL  value of dout while reset is low, <= MOD_MAX
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (deassert synchronously to clk)
//   en     count enable, one step per clock
//   load   synchronous load of din (clamped to MOD_MAX), beats en
//   din    load value
//   up     direction: 1 = increment, 0 = decrement
//   sat    1 = saturate at range ends instead of wrapping
//          (present only when COUNTER_SAT_EN is defined)
//   dout   registered count
//   tc     combinational terminal count for the current direction
//   wrap   registered pulse, high in the cycle dout shows a wrapped value
//
// Build option: define COUNTER_SAT_EN to add the sat port and the
// saturating mode; otherwise the counter always wraps.

module counter_mod
   import counter_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int MOD_MAX = (1 << WIDTH) - 1,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             up,
`ifdef COUNTER_SAT_EN
   input  logic             sat,
`endif
   output logic [WIDTH-1:0] dout,
   output logic             tc,
   output logic             wrap
);

   // Parameter legality is checked at elaboration time.
   if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
      $error("counter_mod: WIDTH must be 1..%0d", CNT_MAX_W);
   end
   if (MOD_MAX < 0 || longint'(MOD_MAX) > (longint'(1) << WIDTH) - 1) begin : g_bad_mod_max
      $error("counter_mod: MOD_MAX exceeds 2**WIDTH-1");
   end
   if (RST_VAL < 0 || RST_VAL > MOD_MAX) begin : g_bad_rst_val
      $error("counter_mod: RST_VAL exceeds MOD_MAX");
   end

   localparam logic [WIDTH-1:0] MOD_MAX_W = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

   logic             sat_mode;
   cnt_next_t        step;
   logic [WIDTH-1:0] dout_next;
   logic             wrap_next;

`ifdef COUNTER_SAT_EN
   assign sat_mode = sat;
`else
   // Constant zero lets the saturation branches fold away.
   assign sat_mode = 1'b0;
`endif

   always_comb begin
      step      = next_count(CNT_MAX_W'(dout), up, CNT_MAX_W'(MOD_MAX_W), sat_mode);
      dout_next = dout;
      wrap_next = 1'b0;
      if (load) begin
         dout_next = (din > MOD_MAX_W) ? MOD_MAX_W : din;
      end else if (en) begin
         dout_next = WIDTH'(step.value);
         wrap_next = step.wrap;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout <= RST_VAL_W;
         wrap <= 1'b0;
      end else begin
         dout <= dout_next;
         wrap <= wrap_next;
      end
   end

   assign tc = (up == CNT_UP) ? (dout == MOD_MAX_W) : (dout == '0);

endmodule

// File: doc/counter_mod.md
# counter_mod

Parametrised loadable up/down modulo counter, the general-purpose successor to the fixed 4-bit loadable counter. Counts over 0..MOD_MAX with per-cycle enable, direction select, synchronous parallel load, and a registered wrap pulse. An optional saturating mode is compiled in by macro. Used wherever the design needs event counting, timeouts, or divide-by-N tick generation.

## Interface
- WIDTH, 8, counter width in bits
- MOD_MAX, 2**WIDTH-1, highest count value; count range is 0..MOD_MAX
- RST_VAL, 0, value loaded into dout on reset

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- en  input  1  count enable; one step per clock while high
- load  input  1  synchronous load of din; higher priority than en
- din  input  WIDTH  load value
- up  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  1 = saturate at the range ends instead of wrapping; port present only with COUNTER_SAT_EN
- dout  output  WIDTH  current count, registered
- tc  output  1  terminal count, combinational: dout==MOD_MAX when up=1, dout==0 when up=0
- wrap  output  1  registered one-cycle pulse, high in the cycle dout shows a wrapped value

## Operation
- Elaboration error if MOD_MAX > 2**WIDTH-1 or RST_VAL > MOD_MAX.
- Next-state priority, evaluated each rising clk: load, then en, then hold.
- load=1: dout <= min(din, MOD_MAX); wrap <= 0. en and up are ignored.
- load=0, en=1, up=1: dout==MOD_MAX -> dout <= 0, wrap <= 1; otherwise dout <= dout+1, wrap <= 0.
- load=0, en=1, up=0: dout==0 -> dout <= MOD_MAX, wrap <= 1; otherwise dout <= dout-1, wrap <= 0.
- load=0, en=0: dout holds; wrap <= 0.
- Saturating mode (sat=1): at the range end in the count direction, dout holds and wrap stays 0. tc still flags the end.
- Arithmetic is WIDTH bits unsigned. Compare against MOD_MAX before incrementing so that no intermediate value overflows.
- No FSM; a single count register plus the wrap flop.

## Timing
- Reset asserted (low): dout = RST_VAL and wrap = 0 immediately, without waiting for clk. All inputs are ignored while reset is low.
- Reset deassertion must be synchronous to clk; the deassertion synchroniser lives outside this block.
- Latency: one clock from input sample to the dout/wrap update. tc follows dout and up combinationally with zero cycles of latency.
- wrap is never high for two consecutive cycles unless wraps occur back-to-back, e.g. MOD_MAX=0 with en held high.
- Reset asserted mid-count overrides everything. The first count after release starts from RST_VAL.

## Configuration
- COUNTER_SAT_EN defined: the sat port exists and saturating mode works as described above.
- COUNTER_SAT_EN undefined: no sat port; the counter always wraps; the saturation logic is absent.

## Structure
- counter_pkg: direction constants CNT_UP/CNT_DOWN and a next-count function (value, up, MOD_MAX, sat) returning next value and wrap flag, so other counters can reuse it.
- No sub-modules; a single flat module of count register, next-state mux, and wrap flop.

## Test plan
(Bench uses WIDTH=4, MOD_MAX=9, RST_VAL=0.)
- reset low for 10 ns, then high with en=0 for 10 cycles -> dout=0, wrap=0 throughout.
- en=1, up=1 from 0 -> after 9 edges dout=9 and tc=1; 10th edge -> dout=0, wrap=1 for exactly one cycle.
- load=1 with din=4'hA -> dout=9 (clamped). load=1, en=1, din=3 -> dout=3, no count that cycle.
- en=1, up=0 from dout=0 -> dout=9 and wrap=1; next edge -> dout=8, wrap=0.
- COUNTER_SAT_EN, sat=1, up=1 at dout=9 for 3 edges -> dout stays 9, wrap=0. up=0 at 0 -> dout stays 0.
- At dout=5, drive reset low between clock edges -> dout=0 immediately. Release, en=1 -> dout=1 after the first edge.
